vga_wr_arbiter: RTL and testbench

//  Shares the single VGA framebuffer write port (vgax/vgay/vgaw) between the CPU

---
 rtl/vga_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_vga_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_wr_arbiter.sv
// vga_wr_arbiter: shares the framebuffer write port between the CPU datapath and
// a full-screen fill engine. The CPU normally wins arbitration, but once it has
// taken STARVE consecutive slots while a fill is pending, the fill gets the next slot.
module vga_wr_arbiter #(
  parameter int XW     = 8,
  parameter int YW     = 8,
  parameter int XMAX   = 159,
  parameter int YMAX   = 119,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [XW-1:0] cpu_x,
  input  logic [YW-1:0] cpu_y,
  input  logic          cpu_pix,
  output logic          cpu_gnt,
  input  logic          fill_start,
  input  logic          fill_abort,
  input  logic          fill_pix,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic          vga_pix,
  output logic          vga_we
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(XMAX);
  localparam logic [YW-1:0] Y_LAST = YW'(YMAX);
  localparam logic [SW-1:0] S_LIM  = SW'(STARVE);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] fx_reg;
  logic [YW-1:0] fy_reg;
  logic [SW-1:0] starve_reg;
  logic          pix_reg;
  logic          fill_we;
  logic          last_pix;

  assign last_pix  = (fx_reg == X_LAST) && (fy_reg == Y_LAST);
  assign fill_busy = (state_reg == FILL);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: enter FILL on start, leave on abort or after the last pixel
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (fill_start) state_next = FILL;
      FILL: if (fill_abort || (fill_we && last_pix)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slot arbitration; cpu_gnt is forced low while reset is held
  always_comb begin
    cpu_gnt = 1'b0;
    fill_we = 1'b0;
    case (state_reg)
      IDLE: cpu_gnt = cpu_req;
      FILL: begin
        // an abort cycle never writes fill data, so the CPU may always take it
        cpu_gnt = cpu_req && (fill_abort || (starve_reg < S_LIM));
        fill_we = !fill_abort && !cpu_gnt;
      end
      default: ;
    endcase
    if (!reset) cpu_gnt = 1'b0;
  end

  // Fill raster position, starvation counter and latched fill value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fx_reg     <= '0;
      fy_reg     <= '0;
      starve_reg <= '0;
      pix_reg    <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (fill_start) begin
        fx_reg     <= '0;
        fy_reg     <= '0;
        starve_reg <= '0;
        pix_reg    <= fill_pix;
      end
    end else if (fill_we) begin
      starve_reg <= '0;
      if (fx_reg == X_LAST) begin
        fx_reg <= '0;
        // the last row is never stepped past; the fill ends there
        if (fy_reg != Y_LAST) fy_reg <= fy_reg + 1'b1;
      end else begin
        fx_reg <= fx_reg + 1'b1;
      end
    end else if (cpu_gnt && !fill_abort) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

  // Registered write port: the granted write appears one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_x     <= '0;
      vga_y     <= '0;
      vga_pix   <= 1'b0;
      vga_we    <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      vga_we    <= cpu_gnt || fill_we;
      fill_done <= fill_we && last_pix;
      if (cpu_gnt) begin
        vga_x   <= cpu_x;
        vga_y   <= cpu_y;
        vga_pix <= cpu_pix;
      end else if (fill_we) begin
        vga_x   <= fx_reg;
        vga_y   <= fy_reg;
        vga_pix <= pix_reg;
      end
    end
  end

endmodule

// File: tb/tb_vga_wr_arbiter.sv
// Directed bench for vga_wr_arbiter with a 4x2 fill area and STARVE=4.
module tb_vga_wr_arbiter;

  localparam int XW = 8;
  localparam int YW = 8;

  logic          clk;
  logic          reset;
  logic          cpu_req;
  logic [XW-1:0] cpu_x;
  logic [YW-1:0] cpu_y;
  logic          cpu_pix;
  logic          cpu_gnt;
  logic          fill_start;
  logic          fill_abort;
  logic          fill_pix;
  logic          fill_busy;
  logic          fill_done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic          vga_pix;
  logic          vga_we;

  int checks = 0;
  int errors = 0;

  vga_wr_arbiter #(.XW(XW), .YW(YW), .XMAX(3), .YMAX(1), .STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_pix(cpu_pix),
    .cpu_gnt(cpu_gnt),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_pix(fill_pix),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_pix(vga_pix), .vga_we(vga_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req = 0; cpu_x = 0; cpu_y = 0; cpu_pix = 0;
    fill_start = 0; fill_abort = 0; fill_pix = 0;
    tick(); tick();
    checks++;
    if ({vga_we, vga_pix, vga_x, vga_y, fill_busy, fill_done, cpu_gnt} !== '0) begin
      errors++; $display("FAIL reset_init outputs got %b want 0",
        {vga_we, vga_pix, vga_x, vga_y, fill_busy, fill_done, cpu_gnt});
    end
    reset = 1'b1;
    // start traffic, then assert reset in the middle of a cycle
    fill_pix = 1; fill_start = 1; tick(); fill_start = 0;
    tick(); tick();
    cpu_req = 1; cpu_x = 8'd33; cpu_y = 8'd44; cpu_pix = 1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({vga_we, vga_pix, vga_x, vga_y, fill_busy, fill_done, cpu_gnt} !== '0) begin
      errors++; $display("FAIL reset_mid outputs got %b want 0",
        {vga_we, vga_pix, vga_x, vga_y, fill_busy, fill_done, cpu_gnt});
    end
    tick();
    cpu_req = 0;
    reset = 1'b1;
    tick();
    checks++;
    if (vga_we !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      errors++; $display("FAIL reset_release we=%b busy=%b done=%b want 0 0 0",
        vga_we, fill_busy, fill_done);
    end
    $display("test_reset done");
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_x = 8'd10; cpu_y = 8'd20; cpu_pix = 1;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL cpu_gnt got %b want 1", cpu_gnt);
    end
    tick();
    cpu_req = 0;
    checks++;
    if (vga_we !== 1'b1 || vga_x !== 8'd10 || vga_y !== 8'd20 || vga_pix !== 1'b1) begin
      errors++; $display("FAIL cpu_write got we=%b x=%0d y=%0d pix=%b want 1 10 20 1",
        vga_we, vga_x, vga_y, vga_pix);
    end
    #1;
    checks++;
    if (cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL cpu_gnt_noreq got %b want 0", cpu_gnt);
    end
    tick();
    checks++;
    if (vga_we !== 1'b0 || vga_x !== 8'd10) begin
      errors++; $display("FAIL idle_hold got we=%b x=%0d want 0 10", vga_we, vga_x);
    end
    $display("test_cpu_write done");
  endtask

  task automatic test_fill();
    fill_pix = 1; fill_start = 1; tick(); fill_start = 0; fill_pix = 0;
    checks++;
    if (fill_busy !== 1'b1) begin
      errors++; $display("FAIL fill_busy_start got %b want 1", fill_busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (vga_we !== 1'b1 || vga_x !== 8'(i % 4) || vga_y !== 8'(i / 4) || vga_pix !== 1'b1) begin
        errors++; $display("FAIL fill_px%0d got we=%b (%0d,%0d) pix=%b want 1 (%0d,%0d) 1",
          i, vga_we, vga_x, vga_y, vga_pix, i % 4, i / 4);
      end
      checks++;
      if (fill_done !== (i == 7) || fill_busy !== (i != 7)) begin
        errors++; $display("FAIL fill_flags%0d got done=%b busy=%b want %b %b",
          i, fill_done, fill_busy, i == 7, i != 7);
      end
    end
    tick();
    checks++;
    if (fill_done !== 1'b0 || vga_we !== 1'b0) begin
      errors++; $display("FAIL fill_after got done=%b we=%b want 0 0", fill_done, vga_we);
    end
    $display("test_fill done");
  endtask

  task automatic test_starve();
    fill_pix = 1; fill_start = 1; tick(); fill_start = 0;
    cpu_req = 1; cpu_x = 8'd50; cpu_y = 8'd60; cpu_pix = 0;
    for (int p = 0; p < 8; p++) begin
      for (int g = 0; g < 4; g++) begin
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
          errors++; $display("FAIL starve_gnt p%0d g%0d got %b want 1", p, g, cpu_gnt);
        end
        tick();
        checks++;
        if (vga_we !== 1'b1 || vga_x !== 8'd50 || vga_y !== 8'd60 || vga_pix !== 1'b0) begin
          errors++; $display("FAIL starve_cpu p%0d g%0d got we=%b (%0d,%0d) pix=%b want 1 (50,60) 0",
            p, g, vga_we, vga_x, vga_y, vga_pix);
        end
      end
      #1;
      checks++;
      if (cpu_gnt !== 1'b0) begin
        errors++; $display("FAIL starve_block p%0d got %b want 0", p, cpu_gnt);
      end
      tick();
      checks++;
      if (vga_we !== 1'b1 || vga_x !== 8'(p % 4) || vga_y !== 8'(p / 4) || vga_pix !== 1'b1) begin
        errors++; $display("FAIL starve_fill p%0d got we=%b (%0d,%0d) pix=%b want 1 (%0d,%0d) 1",
          p, vga_we, vga_x, vga_y, vga_pix, p % 4, p / 4);
      end
    end
    cpu_req = 0;
    checks++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      errors++; $display("FAIL starve_done got done=%b busy=%b want 1 0", fill_done, fill_busy);
    end
    tick();
    $display("test_starve done");
  endtask

  task automatic test_abort();
    fill_pix = 1; fill_start = 1; tick(); fill_start = 0;
    tick(); tick(); tick();
    checks++;
    if (vga_we !== 1'b1 || vga_x !== 8'd2 || vga_y !== 8'd0) begin
      errors++; $display("FAIL abort_pre got we=%b (%0d,%0d) want 1 (2,0)", vga_we, vga_x, vga_y);
    end
    fill_abort = 1;
    tick();
    fill_abort = 0;
    checks++;
    if (vga_we !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      errors++; $display("FAIL abort_cycle got we=%b busy=%b done=%b want 0 0 0",
        vga_we, fill_busy, fill_done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (vga_we !== 1'b0 || fill_done !== 1'b0) begin
        errors++; $display("FAIL abort_quiet%0d got we=%b done=%b want 0 0", i, vga_we, fill_done);
      end
    end
    // abort in IDLE has no effect; restart begins at (0,0)
    fill_abort = 1; tick(); fill_abort = 0;
    fill_pix = 0; fill_start = 1; tick(); fill_start = 0;
    tick();
    checks++;
    if (vga_we !== 1'b1 || vga_x !== 8'd0 || vga_y !== 8'd0 || vga_pix !== 1'b0) begin
      errors++; $display("FAIL abort_restart got we=%b (%0d,%0d) pix=%b want 1 (0,0) 0",
        vga_we, vga_x, vga_y, vga_pix);
    end
    // abort with a CPU request in the same cycle: CPU still granted
    cpu_req = 1; cpu_x = 8'd5; cpu_y = 8'd6; cpu_pix = 1; fill_abort = 1;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL abort_cpu_gnt got %b want 1", cpu_gnt);
    end
    tick();
    cpu_req = 0; fill_abort = 0;
    checks++;
    if (vga_we !== 1'b1 || vga_x !== 8'd5 || fill_busy !== 1'b0) begin
      errors++; $display("FAIL abort_cpu got we=%b x=%0d busy=%b want 1 5 0", vga_we, vga_x, fill_busy);
    end
    tick();
    $display("test_abort done");
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_x = 8'd7; cpu_y = 8'd9; cpu_pix = 1;
    fill_start = 1; fill_pix = 0;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_gnt got %b want 1", cpu_gnt);
    end
    tick();
    cpu_req = 0; fill_start = 0;
    checks++;
    if (vga_we !== 1'b1 || vga_x !== 8'd7 || vga_y !== 8'd9 || fill_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_cpu got we=%b (%0d,%0d) busy=%b want 1 (7,9) 1",
        vga_we, vga_x, vga_y, fill_busy);
    end
    tick();
    checks++;
    if (vga_we !== 1'b1 || vga_x !== 8'd0 || vga_y !== 8'd0 || vga_pix !== 1'b0) begin
      errors++; $display("FAIL b2b_first got we=%b (%0d,%0d) pix=%b want 1 (0,0) 0",
        vga_we, vga_x, vga_y, vga_pix);
    end
    // fill_start during FILL: no restart and no new value
    fill_start = 1; fill_pix = 1;
    for (int i = 1; i < 8; i++) begin
      tick();
      fill_start = 0;
      checks++;
      if (vga_we !== 1'b1 || vga_x !== 8'(i % 4) || vga_y !== 8'(i / 4) || vga_pix !== 1'b0) begin
        errors++; $display("FAIL b2b_px%0d got we=%b (%0d,%0d) pix=%b want 1 (%0d,%0d) 0",
          i, vga_we, vga_x, vga_y, vga_pix, i % 4, i / 4);
      end
    end
    checks++;
    if (fill_done !== 1'b1) begin
      errors++; $display("FAIL b2b_done got %b want 1", fill_done);
    end
    tick();
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_fill();
    test_starve();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
